// File: rtl/vctcxo_ram_arbiter_if.sv
// Bundle of the host (Avalon), logger and RAM-side signals around the tamer scratch RAM arbiter.
// Port summary: host_* Avalon byte port, log_* logger push port and pointer status, ram_* single-port RAM.
// Modports: slave = arbiter view, master = surrounding logic / RAM view.
interface vctcxo_ram_arbiter_if;
  // Host (Nios Avalon) side
  logic [7:0]  host_address;
  logic        host_read;
  logic        host_write;
  logic [7:0]  host_writedata;
  logic        host_waitrequest;
  logic [7:0]  host_readdata;
  logic        host_readdatavalid;
  // Logger side
  logic        log_valid;
  logic [31:0] log_data;
  logic        log_ready;
  logic [7:0]  log_wr_ptr;
  logic        log_wrapped;
  // RAM primitive side
  logic [7:0]  ram_address;
  logic        ram_wren;
  logic [7:0]  ram_writedata;
  logic [7:0]  ram_q;

  modport slave (
    input  host_address, host_read, host_write, host_writedata,
    input  log_valid, log_data, ram_q,
    output host_waitrequest, host_readdata, host_readdatavalid,
    output log_ready, log_wr_ptr, log_wrapped,
    output ram_address, ram_wren, ram_writedata
  );

  modport master (
    output host_address, host_read, host_write, host_writedata,
    output log_valid, log_data, ram_q,
    input  host_waitrequest, host_readdata, host_readdatavalid,
    input  log_ready, log_wr_ptr, log_wrapped,
    input  ram_address, ram_wren, ram_writedata
  );
endinterface

// File: rtl/vctcxo_ram_arbiter.sv
// Shares the vctcxo tamer 256x8 scratch RAM between the Nios host and the tuning-error logger;
// host accesses take 1 cycle, a logged 32-bit sample is written as 4 little-endian bytes over 4 cycles.
// Backpressure: host_waitrequest stalls the host, log_ready is low while the 1-entry holding register is busy.
// Ports: clk, reset (async, active-high), bus (vctcxo_ram_arbiter_if.slave: host_*, log_*, ram_*).
// Optional macro VCTCXO_RAM_ARB_PROTECT_EN: host writes into the log region are accepted but dropped.
module vctcxo_ram_arbiter #(
  parameter logic [7:0] LOG_BASE  = 8'h80,
  parameter int         LOG_WORDS = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  vctcxo_ram_arbiter_if.slave        bus
);

  typedef enum logic [1:0] {IDLE, LOG_B1, LOG_B2, LOG_B3} state_t;
  typedef enum logic {GRANT_HOST, GRANT_LOG} grant_t;

  state_t      state_q, state_d;
  grant_t      last_grant_q, last_grant_d;
  logic [31:0] hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic [7:0]  ptr_q, ptr_d;
  logic        wrapped_q, wrapped_d;
  logic [7:0]  ram_addr_q, ram_addr_d;
  logic [7:0]  ram_wdata_q, ram_wdata_d;
  logic        rdv_q, rdv_d;

  logic        ram_wren;
  logic        host_wait;
  logic        log_ready;
  logic        host_req;
  logic        host_in_log;
  logic [7:0]  log_addr;

  // Byte address of byte 0 of the current log entry.
  assign log_addr = LOG_BASE + (ptr_q << 2);

`ifdef VCTCXO_RAM_ARB_PROTECT_EN
  localparam logic [8:0] LOG_LAST = 9'(int'(LOG_BASE) + 4 * LOG_WORDS - 1);
  assign host_in_log = (bus.host_address >= LOG_BASE) && ({1'b0, bus.host_address} <= LOG_LAST);
`else
  assign host_in_log = 1'b0;
`endif

  // Host request is masked during reset so waitrequest shows its reset value.
  assign host_req  = (bus.host_read | bus.host_write) & ~reset;

  // The holding register frees up in the byte-3 cycle, so a new sample can land right then.
  assign log_ready = ~hold_full_q | (state_q == LOG_B3);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    ptr_d        = ptr_q;
    wrapped_d    = wrapped_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    rdv_d        = 1'b0;
    ram_wren     = 1'b0;
    host_wait    = 1'b1;

    unique case (state_q)
      IDLE: begin
        // Round-robin: on contention the side not granted last time wins.
        if (host_req && (!hold_full_q || last_grant_q == GRANT_LOG)) begin
          host_wait    = 1'b0;
          last_grant_d = GRANT_HOST;
          ram_addr_d   = bus.host_address;
          if (bus.host_write) begin
            // Read+write together is a write; no read data returned.
            ram_wdata_d = bus.host_writedata;
            ram_wren    = ~host_in_log;
          end else begin
            rdv_d = 1'b1;
          end
        end else if (hold_full_q) begin
          ram_addr_d  = log_addr;
          ram_wdata_d = hold_q[7:0];
          ram_wren    = 1'b1;
          state_d     = LOG_B1;
        end
      end
      LOG_B1: begin
        ram_addr_d  = log_addr + 8'd1;
        ram_wdata_d = hold_q[15:8];
        ram_wren    = 1'b1;
        state_d     = LOG_B2;
      end
      LOG_B2: begin
        ram_addr_d  = log_addr + 8'd2;
        ram_wdata_d = hold_q[23:16];
        ram_wren    = 1'b1;
        state_d     = LOG_B3;
      end
      LOG_B3: begin
        ram_addr_d   = log_addr + 8'd3;
        ram_wdata_d  = hold_q[31:24];
        ram_wren     = 1'b1;
        hold_full_d  = 1'b0;
        last_grant_d = GRANT_LOG;
        state_d      = IDLE;
        if (ptr_q == 8'(LOG_WORDS - 1)) begin
          ptr_d     = 8'd0;
          wrapped_d = 1'b1;
        end else begin
          ptr_d = ptr_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Capture after the byte-3 clear so a same-cycle push wins.
    if (bus.log_valid && log_ready) begin
      hold_d      = bus.log_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_LOG;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      ptr_q        <= '0;
      wrapped_q    <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      rdv_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      ptr_q        <= ptr_d;
      wrapped_q    <= wrapped_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      rdv_q        <= rdv_d;
    end
  end

  // The RAM registers the address itself, so address/data go out combinationally
  // and hold their last value when there is no access.
  assign bus.ram_address        = ram_addr_d;
  assign bus.ram_writedata      = ram_wdata_d;
  assign bus.ram_wren           = ram_wren;
  assign bus.host_waitrequest   = host_wait;
  assign bus.host_readdatavalid = rdv_q;
  assign bus.host_readdata      = rdv_q ? bus.ram_q : 8'h00;
  assign bus.log_ready          = log_ready;
  assign bus.log_wr_ptr         = ptr_q;
  assign bus.log_wrapped        = wrapped_q;

endmodule

// File: tb/tb_vctcxo_ram_arbiter.sv
module tb_vctcxo_ram_arbiter;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  vctcxo_ram_arbiter_if bus ();

  vctcxo_ram_arbiter #(
    .LOG_BASE  (8'h80),
    .LOG_WORDS (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // RAM model: registered address, unregistered q.
  logic [7:0] mem [256];
  logic [7:0] ram_addr_r;
  always @(posedge clk) begin
    if (bus.ram_wren) mem[bus.ram_address] <= bus.ram_writedata;
    ram_addr_r <= bus.ram_address;
  end
  assign bus.ram_q = mem[ram_addr_r];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++; if (bus.host_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_wait got %b exp 1", bus.host_waitrequest); end
    checks++; if (bus.host_readdatavalid !== 1'b0) begin errors++; $display("FAIL rst_rdv got %b exp 0", bus.host_readdatavalid); end
    checks++; if (bus.host_readdata !== 8'h00) begin errors++; $display("FAIL rst_rdata got %h exp 00", bus.host_readdata); end
    checks++; if (bus.log_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", bus.log_ready); end
    checks++; if (bus.log_wr_ptr !== 8'd0) begin errors++; $display("FAIL rst_ptr got %0d exp 0", bus.log_wr_ptr); end
    checks++; if (bus.log_wrapped !== 1'b0) begin errors++; $display("FAIL rst_wrapped got %b exp 0", bus.log_wrapped); end
    checks++; if (bus.ram_address !== 8'h00) begin errors++; $display("FAIL rst_addr got %h exp 00", bus.ram_address); end
    checks++; if (bus.ram_wren !== 1'b0) begin errors++; $display("FAIL rst_wren got %b exp 0", bus.ram_wren); end
    checks++; if (bus.ram_writedata !== 8'h00) begin errors++; $display("FAIL rst_wdata got %h exp 00", bus.ram_writedata); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step();
  endtask

  task automatic test_host_rw();
    bus.host_address = 8'h10; bus.host_write = 1'b1; bus.host_writedata = 8'h5A;
    #1;
    checks++; if (bus.host_waitrequest !== 1'b0) begin errors++; $display("FAIL hw_wait got %b exp 0", bus.host_waitrequest); end
    checks++; if (bus.ram_wren !== 1'b1 || bus.ram_address !== 8'h10 || bus.ram_writedata !== 8'h5A) begin
      errors++; $display("FAIL hw_ram got wren=%b addr=%h data=%h exp 1/10/5a", bus.ram_wren, bus.ram_address, bus.ram_writedata); end
    step();
    bus.host_write = 1'b0; bus.host_read = 1'b1;
    #1;
    checks++; if (bus.host_waitrequest !== 1'b0 || bus.ram_wren !== 1'b0) begin
      errors++; $display("FAIL hr_grant got wait=%b wren=%b exp 0/0", bus.host_waitrequest, bus.ram_wren); end
    step();
    bus.host_read = 1'b0;
    #1;
    checks++; if (bus.host_readdatavalid !== 1'b1 || bus.host_readdata !== 8'h5A) begin
      errors++; $display("FAIL hr_data got rdv=%b data=%h exp 1/5a", bus.host_readdatavalid, bus.host_readdata); end
    step();
    checks++; if (bus.host_readdatavalid !== 1'b0 || bus.host_waitrequest !== 1'b1) begin
      errors++; $display("FAIL hr_idle got rdv=%b wait=%b exp 0/1", bus.host_readdatavalid, bus.host_waitrequest); end
  endtask

  task automatic test_log_single();
    logic [7:0] exp_d [4];
    exp_d[0] = 8'hEF; exp_d[1] = 8'hBE; exp_d[2] = 8'hAD; exp_d[3] = 8'hDE;
    bus.log_valid = 1'b1; bus.log_data = 32'hDEADBEEF;
    #1;
    checks++; if (bus.log_ready !== 1'b1 || bus.ram_wren !== 1'b0) begin
      errors++; $display("FAIL log_push got ready=%b wren=%b exp 1/0", bus.log_ready, bus.ram_wren); end
    step();
    bus.log_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (bus.ram_wren !== 1'b1 || bus.ram_address !== 8'(8'h80 + i) || bus.ram_writedata !== exp_d[i]
          || bus.log_ready !== (i == 3) || bus.host_waitrequest !== 1'b1) begin
        errors++;
        $display("FAIL log_byte%0d got wren=%b addr=%h data=%h ready=%b wait=%b exp 1/%h/%h/%b/1",
                 i, bus.ram_wren, bus.ram_address, bus.ram_writedata, bus.log_ready,
                 bus.host_waitrequest, 8'(8'h80 + i), exp_d[i], (i == 3));
      end
      step();
    end
    checks++; if (bus.ram_wren !== 1'b0 || bus.log_wr_ptr !== 8'd1 || bus.ram_address !== 8'h83) begin
      errors++; $display("FAIL log_done got wren=%b ptr=%0d addr=%h exp 0/1/83", bus.ram_wren, bus.log_wr_ptr, bus.ram_address); end
    checks++; if ({mem[8'h83], mem[8'h82], mem[8'h81], mem[8'h80]} !== 32'hDEADBEEF) begin
      errors++; $display("FAIL log_mem got %h exp deadbeef", {mem[8'h83], mem[8'h82], mem[8'h81], mem[8'h80]}); end
  endtask

  task automatic test_host_during_log();
    bus.log_valid = 1'b1; bus.log_data = 32'h11223344;
    step();
    bus.log_valid = 1'b0;
    #1;
    checks++; if (bus.ram_address !== 8'h84 || bus.ram_writedata !== 8'h44) begin
      errors++; $display("FAIL hdl_b0 got addr=%h data=%h exp 84/44", bus.ram_address, bus.ram_writedata); end
    step();
    bus.host_read = 1'b1; bus.host_address = 8'h10;
    for (int i = 1; i < 4; i++) begin
      #1;
      checks++; if (bus.host_waitrequest !== 1'b1) begin errors++; $display("FAIL hdl_stall%0d got %b exp 1", i, bus.host_waitrequest); end
      step();
    end
    #1;
    checks++; if (bus.host_waitrequest !== 1'b0 || bus.ram_wren !== 1'b0 || bus.ram_address !== 8'h10) begin
      errors++; $display("FAIL hdl_grant got wait=%b wren=%b addr=%h exp 0/0/10", bus.host_waitrequest, bus.ram_wren, bus.ram_address); end
    step();
    bus.host_read = 1'b0;
    #1;
    checks++; if (bus.host_readdatavalid !== 1'b1 || bus.host_readdata !== 8'h5A || bus.log_wr_ptr !== 8'd2) begin
      errors++; $display("FAIL hdl_rdata got rdv=%b data=%h ptr=%0d exp 1/5a/2", bus.host_readdatavalid, bus.host_readdata, bus.log_wr_ptr); end
    step();
  endtask

  task automatic test_round_robin();
    logic exp_host;
    for (int c = 0; c < 15; c++) begin
      if (c == 0) begin
        bus.host_read = 1'b1; bus.host_address = 8'h10;
        bus.log_valid = 1'b1; bus.log_data = 32'hA3A2A1A0;
      end
      if (c == 10) bus.log_valid = 1'b0;
      if (c == 11) bus.host_read = 1'b0;
      #1;
      exp_host = (c % 5 == 0);
      checks++;
      if (bus.host_waitrequest !== !exp_host || bus.ram_wren !== !exp_host
          || bus.host_readdatavalid !== (c % 5 == 1)) begin
        errors++;
        $display("FAIL rr_cycle%0d got wait=%b wren=%b rdv=%b exp %b/%b/%b", c, bus.host_waitrequest,
                 bus.ram_wren, bus.host_readdatavalid, !exp_host, !exp_host, (c % 5 == 1));
      end
      step();
    end
    checks++; if (bus.log_wr_ptr !== 8'd5) begin errors++; $display("FAIL rr_ptr got %0d exp 5", bus.log_wr_ptr); end
  endtask

  task automatic push_sample(input logic [31:0] d);
    int n;
    bus.log_valid = 1'b1; bus.log_data = d;
    #1;
    n = 0;
    while (!bus.log_ready && n < 20) begin step(); n++; end
    if (n == 20) begin checks++; errors++; $display("FAIL push_timeout got ready=0 exp 1"); end
    step();
    bus.log_valid = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 26; i++) push_sample(32'h1000 + i);
    checks++; if (bus.log_wr_ptr !== 8'd31 || bus.log_wrapped !== 1'b0) begin
      errors++; $display("FAIL wrap_pre got ptr=%0d wrapped=%b exp 31/0", bus.log_wr_ptr, bus.log_wrapped); end
    push_sample(32'h2000);
    checks++; if (bus.log_wr_ptr !== 8'd0 || bus.log_wrapped !== 1'b1) begin
      errors++; $display("FAIL wrap_at got ptr=%0d wrapped=%b exp 0/1", bus.log_wr_ptr, bus.log_wrapped); end
    checks++; if ({mem[8'hFF], mem[8'hFE], mem[8'hFD], mem[8'hFC]} !== 32'h2000) begin
      errors++; $display("FAIL wrap_last got %h exp 00002000", {mem[8'hFF], mem[8'hFE], mem[8'hFD], mem[8'hFC]}); end
    push_sample(32'hCAFEF00D);
    checks++; if ({mem[8'h83], mem[8'h82], mem[8'h81], mem[8'h80]} !== 32'hCAFEF00D || bus.log_wr_ptr !== 8'd1 || bus.log_wrapped !== 1'b1) begin
      errors++; $display("FAIL wrap_s33 got mem=%h ptr=%0d wrapped=%b exp cafef00d/1/1",
                         {mem[8'h83], mem[8'h82], mem[8'h81], mem[8'h80]}, bus.log_wr_ptr, bus.log_wrapped); end
  endtask

  task automatic test_protect();
    logic [7:0] exp_rd;
    logic       exp_wren;
`ifdef VCTCXO_RAM_ARB_PROTECT_EN
    exp_rd = 8'h44; exp_wren = 1'b0;
`else
    exp_rd = 8'h11; exp_wren = 1'b1;
`endif
    bus.host_address = 8'h84; bus.host_write = 1'b1; bus.host_writedata = 8'h11;
    #1;
    checks++; if (bus.host_waitrequest !== 1'b0 || bus.ram_wren !== exp_wren) begin
      errors++; $display("FAIL prot_wr got wait=%b wren=%b exp 0/%b", bus.host_waitrequest, bus.ram_wren, exp_wren); end
    step();
    bus.host_write = 1'b0; bus.host_read = 1'b1;
    #1;
    checks++; if (bus.host_waitrequest !== 1'b0) begin errors++; $display("FAIL prot_rdgrant got %b exp 0", bus.host_waitrequest); end
    step();
    bus.host_read = 1'b0;
    #1;
    checks++; if (bus.host_readdatavalid !== 1'b1 || bus.host_readdata !== exp_rd) begin
      errors++; $display("FAIL prot_rd got rdv=%b data=%h exp 1/%h", bus.host_readdatavalid, bus.host_readdata, exp_rd); end
    step();
  endtask

  task automatic test_reset_mid_log();
    bus.log_valid = 1'b1; bus.log_data = 32'h55667788;
    step();
    bus.log_valid = 1'b0;
    step();
    #1;
    reset = 1'b1;
    #1;
    checks++; if (bus.ram_wren !== 1'b0 || bus.log_ready !== 1'b1 || bus.log_wr_ptr !== 8'd0) begin
      errors++; $display("FAIL rml_rst got wren=%b ready=%b ptr=%0d exp 0/1/0", bus.ram_wren, bus.log_ready, bus.log_wr_ptr); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (bus.ram_wren !== 1'b0) begin errors++; $display("FAIL rml_idle%0d got wren=%b exp 0", i, bus.ram_wren); end
    end
    checks++; if (mem[8'h84] !== 8'h88 || mem[8'h85] !== 8'h33) begin
      errors++; $display("FAIL rml_mem got %h %h exp 88 33", mem[8'h84], mem[8'h85]); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    bus.host_address   = 8'h00;
    bus.host_read      = 1'b0;
    bus.host_write     = 1'b0;
    bus.host_writedata = 8'h00;
    bus.log_valid      = 1'b0;
    bus.log_data       = 32'h0;
    test_reset();
    test_host_rw();
    test_log_single();
    test_host_during_log();
    test_round_robin();
    test_wrap();
    test_protect();
    test_reset_mid_log();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
